ftoi_pipe: RTL and testbench

Pipelined, parametrised single-precision float to signed-integer converter for the FPU datapath. It takes an IEEE-754 binary32 operand and returns a signed two's-complement integer of `OUT_W` bits. Five rounding modes are selectable per operation, and it raises invalid and inexact flags. The block sits behind the FPU issue stage on a valid/ready stream, and the FCVT.W.S and FCVT.L.S paths instantiate it.

---
 rtl/ftoi_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_ftoi_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_pipe
// Purpose  : Three-stage pipelined IEEE-754 binary32 to signed integer
//            converter with selectable rounding mode and invalid/inexact
//            flags, on a valid/ready stream with a global stall.
// Ports    : clk, rstn            - clock, asynchronous active-low reset
//            in_valid/in_ready    - operand handshake
//            in_x [31:0]          - binary32 operand
//            in_rm [2:0]          - rounding mode (RNE,RTZ,RDN,RUP,RMM;
//                                   101..111 behave as RMM)
//            out_valid/out_ready  - result handshake
//            out_y [OUT_W-1:0]    - signed two's-complement result
//            out_invalid          - NaN, infinity or overflow
//            out_inexact          - result differs from operand (valid only)
// Revision : 1.0 - initial release
// ============================================================================
module ftoi_pipe #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [2:0]       in_rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic             out_invalid,
   output logic             out_inexact
);

   // Fixed-point alignment buffer: OUT_W integer bits above 24 fraction bits.
   // At shift 0 the significand sits in the fraction field (k = -1).
   localparam int c_fix_w = OUT_W + 24;
   localparam int c_big_e = 127 + OUT_W;

   localparam logic [OUT_W:0]   c_lim     = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] c_int_max = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] c_int_min = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] c_one     = {{(OUT_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------
   // Global stall: the whole pipe moves together or holds together.
   // ------------------------------------------------------------------
   logic w_advance;
   logic r3_valid;

   assign w_advance = !r3_valid || out_ready;
   assign in_ready  = w_advance;

   // ------------------------------------------------------------------
   // Stage 1: unpack and classify
   // ------------------------------------------------------------------
   logic [7:0]  w_e;
   logic [22:0] w_m;
   logic        w_zero;
   logic        w_special;
   logic        w_nan;
   logic        w_tiny;
   logic [6:0]  w_shamt;

   assign w_e       = in_x[30:23];
   assign w_m       = in_x[22:0];
   assign w_zero    = (w_e == 8'd0);
   // Infinity, NaN and any exponent too large to fit skip the shifter.
   assign w_special = (w_e == 8'hFF) || (w_e >= 8'(c_big_e));
   assign w_nan     = (w_e == 8'hFF) && (w_m != 23'd0);
   // Magnitude below 0.5: only the sticky bit survives.
   assign w_tiny    = (w_e < 8'd126);
   assign w_shamt   = w_tiny ? 7'd0 : 7'(w_e - 8'd126);

   logic        r1_valid;
   logic        r1_s;
   logic [2:0]  r1_rm;
   logic        r1_zero;
   logic        r1_special;
   logic        r1_nan;
   logic        r1_tiny;
   logic [23:0] r1_sig;
   logic [6:0]  r1_shamt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r1_valid   <= 1'b0;
         r1_s       <= 1'b0;
         r1_rm      <= 3'd0;
         r1_zero    <= 1'b0;
         r1_special <= 1'b0;
         r1_nan     <= 1'b0;
         r1_tiny    <= 1'b0;
         r1_sig     <= 24'd0;
         r1_shamt   <= 7'd0;
      end else if (w_advance) begin
         r1_valid   <= in_valid;
         r1_s       <= in_x[31];
         r1_rm      <= in_rm;
         r1_zero    <= w_zero;
         r1_special <= w_special;
         r1_nan     <= w_nan;
         r1_tiny    <= w_tiny;
         r1_sig     <= {1'b1, w_m};
         r1_shamt   <= w_shamt;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: align, extract integer part, guard and sticky
   // ------------------------------------------------------------------
   logic [c_fix_w-1:0] w_fixed;
   logic [OUT_W-1:0]   w_int;
   logic               w_guard;
   logic               w_sticky;

   assign w_fixed  = {{OUT_W{1'b0}}, r1_sig} << r1_shamt;
   assign w_int    = r1_tiny ? {OUT_W{1'b0}} : w_fixed[c_fix_w-1:24];
   assign w_guard  = !r1_tiny && w_fixed[23];
   assign w_sticky = r1_tiny || (|w_fixed[22:0]);

   logic             r2_valid;
   logic             r2_s;
   logic [2:0]       r2_rm;
   logic             r2_zero;
   logic             r2_special;
   logic             r2_nan;
   logic [OUT_W-1:0] r2_int;
   logic             r2_guard;
   logic             r2_sticky;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r2_valid   <= 1'b0;
         r2_s       <= 1'b0;
         r2_rm      <= 3'd0;
         r2_zero    <= 1'b0;
         r2_special <= 1'b0;
         r2_nan     <= 1'b0;
         r2_int     <= {OUT_W{1'b0}};
         r2_guard   <= 1'b0;
         r2_sticky  <= 1'b0;
      end else if (w_advance) begin
         r2_valid   <= r1_valid;
         r2_s       <= r1_s;
         r2_rm      <= r1_rm;
         r2_zero    <= r1_zero;
         r2_special <= r1_special;
         r2_nan     <= r1_nan;
         r2_int     <= w_int;
         r2_guard   <= w_guard;
         r2_sticky  <= w_sticky;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: round, range check, negate, flags
   // ------------------------------------------------------------------
   logic           w_inc;
   logic [OUT_W:0] w_mag;
   logic           w_ovf;
   logic [OUT_W-1:0] w_y;
   logic           w_inv;
   logic           w_inx;

   always_comb begin
      w_inc = 1'b0;
      case (r2_rm)
         3'd0:    w_inc = r2_guard && (r2_sticky || r2_int[0]);
         3'd1:    w_inc = 1'b0;
         3'd2:    w_inc = r2_s && (r2_guard || r2_sticky);
         3'd3:    w_inc = !r2_s && (r2_guard || r2_sticky);
         default: w_inc = r2_guard;
      endcase
   end

   // One extra bit so a carry out of the increment is never lost.
   assign w_mag = {1'b0, r2_int} + {{OUT_W{1'b0}}, w_inc};
   // Negative side may reach exactly 2^(OUT_W-1) (INT_MIN) legally.
   assign w_ovf = r2_s ? (w_mag > c_lim) : (w_mag >= c_lim);

   always_comb begin
      w_y   = {OUT_W{1'b0}};
      w_inv = 1'b0;
      w_inx = 1'b0;
      if (r2_zero) begin
         // Zero and denormals: flushed, no flags.
         w_y = {OUT_W{1'b0}};
      end else if (r2_special) begin
         w_inv = 1'b1;
         w_y   = (r2_nan || !r2_s) ? c_int_max : c_int_min;
      end else if (w_ovf) begin
         w_inv = 1'b1;
         w_y   = r2_s ? c_int_min : c_int_max;
      end else begin
         w_y   = r2_s ? (~w_mag[OUT_W-1:0] + c_one) : w_mag[OUT_W-1:0];
         w_inx = r2_guard || r2_sticky;
      end
   end

   logic [OUT_W-1:0] r3_y;
   logic             r3_inv;
   logic             r3_inx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r3_valid <= 1'b0;
         r3_y     <= {OUT_W{1'b0}};
         r3_inv   <= 1'b0;
         r3_inx   <= 1'b0;
      end else if (w_advance) begin
         r3_valid <= r2_valid;
         // Bubbles leave the last result on the bus untouched.
         if (r2_valid) begin
            r3_y   <= w_y;
            r3_inv <= w_inv;
            r3_inx <= w_inx;
         end
      end
   end

   assign out_valid   = r3_valid;
   assign out_y       = r3_y;
   assign out_invalid = r3_inv;
   assign out_inexact = r3_inx;

endmodule
`default_nettype wire

// File: tb/tb_ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftoi_pipe
// Purpose  : Self-checking bench for ftoi_pipe at OUT_W = 32 and 64, driven
//            in lockstep, with a real-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftoi_pipe;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_x = 32'd0;
   logic [2:0]  in_rm = 3'd0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, out_inv_a, out_inx_a;
   logic [31:0] out_y_a;
   logic        in_ready_b, out_valid_b, out_inv_b, out_inx_b;
   logic [63:0] out_y_b;

   always #5 clk = ~clk;

   ftoi_pipe #(.OUT_W(32)) u_dut32 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_x(in_x), .in_rm(in_rm), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_y(out_y_a), .out_invalid(out_inv_a), .out_inexact(out_inx_a));

   ftoi_pipe #(.OUT_W(64)) u_dut64 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_x(in_x), .in_rm(in_rm), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_y(out_y_b), .out_invalid(out_inv_b), .out_inexact(out_inx_b));

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int stall_cum = 0;
   int stall_cnt = 0;
   bit rnd_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] x;
      logic [2:0]  rm;
      int          acc;
      int          st;
      bit          lit;
      bit          lw64;
      logic [63:0] ly;
      bit          linv;
      bit          linx;
   } ent_t;

   ent_t q[$];

   bit          cur_lit = 1'b0;
   bit          cur_lw64 = 1'b0;
   logic [63:0] cur_ly = 64'd0;
   bit          cur_linv = 1'b0;
   bit          cur_linx = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: value of the operand as a real, rounded by the mode's rule,
   // then range-checked against the signed OUT_W-bit range.
   function automatic void model(input logic [31:0] x, input logic [2:0] rm, input int w,
                                 output logic [63:0] y, output logic inv, output logic inx);
      logic        s;
      int          e;
      real         a, fl, fr, lim, r;
      bit          odd, inc;
      logic [63:0] imin, imax, mask;
      longint      mag;
      s    = x[31];
      e    = {24'd0, x[30:23]};
      imin = 64'd1 << (w - 1);
      imax = imin - 64'd1;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      y    = 64'd0;
      inv  = 1'b0;
      inx  = 1'b0;
      if (e == 0) begin
         y = 64'd0;
      end else if (e == 255) begin
         inv = 1'b1;
         y   = (x[22:0] != 23'd0 || !s) ? imax : imin;
      end else begin
         a   = real'({1'b1, x[22:0]}) * (2.0 ** real'(e - 150));
         fl  = $floor(a);
         fr  = a - fl;
         odd = (fl - 2.0 * $floor(fl / 2.0)) != 0.0;
         case (rm)
            3'd0:    inc = (fr > 0.5) || (fr == 0.5 && odd);
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && (fr != 0.0);
            3'd3:    inc = !s && (fr != 0.0);
            default: inc = (fr >= 0.5);
         endcase
         r   = fl + (inc ? 1.0 : 0.0);
         lim = 2.0 ** real'(w - 1);
         if ((!s && r >= lim) || (s && r > lim)) begin
            inv = 1'b1;
            y   = s ? imin : imax;
         end else if (s && r == lim) begin
            y   = imin;
            inx = (fr != 0.0);
         end else begin
            mag = longint'(r);
            y   = s ? 64'(-mag) : 64'(mag);
            inx = (fr != 0.0);
         end
      end
      y = y & mask;
   endfunction

   // ------------------------------------------------------------------
   // Compare process: samples 4 ns after each falling edge.
   // ------------------------------------------------------------------
   initial begin
      logic        prev_stall;
      logic [31:0] py_a;
      logic [63:0] py_b;
      logic [3:0]  pf;
      logic        stall;
      logic [63:0] ey;
      logic        ei, ex;
      ent_t        en;
      prev_stall = 1'b0;
      py_a = '0; py_b = '0; pf = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!rstn) begin
            q.delete();
            prev_stall = 1'b0;
         end else begin
            chk("valid_w32_vs_w64", {63'd0, out_valid_b}, {63'd0, out_valid_a});
            chk("in_ready_rule", {63'd0, in_ready_a}, {63'd0, (!out_valid_a || out_ready)});
            chk("in_ready_w64", {63'd0, in_ready_b}, {63'd0, in_ready_a});
            if (prev_stall) begin
               chk("hold_valid", {63'd0, out_valid_a}, 64'd1);
               chk("hold_y32", {32'd0, out_y_a}, {32'd0, py_a});
               chk("hold_y64", out_y_b, py_b);
               chk("hold_flags", {60'd0, out_inv_a, out_inx_a, out_inv_b, out_inx_b}, {60'd0, pf});
            end
            if (out_valid_a && out_ready) begin
               if (q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_result: got y32=%h with no operand outstanding", out_y_a);
               end else begin
                  en = q.pop_front();
                  model(en.x, en.rm, 32, ey, ei, ex);
                  chk("y32", {32'd0, out_y_a}, ey);
                  chk("flags32", {62'd0, out_inv_a, out_inx_a}, {62'd0, ei, ex});
                  model(en.x, en.rm, 64, ey, ei, ex);
                  chk("y64", out_y_b, ey);
                  chk("flags64", {62'd0, out_inv_b, out_inx_b}, {62'd0, ei, ex});
                  chk("latency", 64'(cyc - en.acc), 64'(3 + stall_cum - en.st));
                  if (en.lit && !en.lw64) begin
                     chk("lit_y32", {32'd0, out_y_a}, {32'd0, en.ly[31:0]});
                     chk("lit_flags32", {62'd0, out_inv_a, out_inx_a}, {62'd0, en.linv, en.linx});
                  end
                  if (en.lit && en.lw64) begin
                     chk("lit_y64", out_y_b, en.ly);
                     chk("lit_flags64", {62'd0, out_inv_b, out_inx_b}, {62'd0, en.linv, en.linx});
                  end
               end
            end
            stall = out_valid_a && !out_ready;
            if (stall) stall_cum++;
            prev_stall = stall;
            py_a = out_y_a;
            py_b = out_y_b;
            pf   = {out_inv_a, out_inx_a, out_inv_b, out_inx_b};
            if (in_valid && in_ready_a) begin
               en.x = in_x; en.rm = in_rm; en.acc = cyc; en.st = stall_cum;
               en.lit = cur_lit; en.lw64 = cur_lw64; en.ly = cur_ly;
               en.linv = cur_linv; en.linx = cur_linx;
               q.push_back(en);
            end
         end
      end
   end

   // Downstream readiness: forced stall window, random, or always ready.
   initial begin
      forever begin
         @(negedge clk);
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic issue(input logic [31:0] x, input logic [2:0] rm, input bit lit,
                        input bit lw64, input logic [63:0] ly, input bit linv, input bit linx);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_x = x; in_rm = rm;
      cur_lit = lit; cur_lw64 = lw64; cur_ly = ly; cur_linv = linv; cur_linx = linx;
      #4;
      n = 0;
      while (!in_ready_a && n < 200) begin
         @(negedge clk);
         #4;
         n++;
      end
      if (!in_ready_a) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: in_ready=%0d required 1 within 200 cycles", in_ready_a);
      end
   endtask

   task automatic lit32(input logic [31:0] x, input logic [2:0] rm, input logic [31:0] y,
                        input bit inv, input bit inx);
      issue(x, rm, 1'b1, 1'b0, {32'd0, y}, inv, inx);
   endtask

   task automatic lit64(input logic [31:0] x, input logic [2:0] rm, input logic [63:0] y,
                        input bit inv, input bit inx);
      issue(x, rm, 1'b1, 1'b1, y, inv, inx);
   endtask

   task automatic rnd_op();
      logic [7:0] e;
      logic [22:0] m;
      int sel;
      sel = $urandom_range(0, 15);
      m   = 23'($urandom);
      if ($urandom_range(0, 3) == 0) m = m & 23'h7F0000;
      if (sel == 0)      e = 8'd0;
      else if (sel == 1) e = 8'hFF;
      else if (sel < 8)  e = 8'($urandom_range(120, 160));
      else               e = 8'($urandom_range(110, 200));
      if (sel == 1 && $urandom_range(0, 1) == 0) m = 23'd0;
      issue({1'($urandom), e, m}, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         cur_lit  = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      #3;
      chk("reset_valid", {63'd0, out_valid_a}, 64'd0);
      chk("reset_y32", {32'd0, out_y_a}, 64'd0);
      chk("reset_flags", {60'd0, out_inv_a, out_inx_a, out_inv_b, out_inx_b}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready_a}, 64'd1);
      @(negedge clk);
      #2 rstn = 1'b1;
      idle(2);

      // Rounding of +/-2.5
      lit32(32'h40200000, 3'd0, 32'd2, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd1, 32'd2, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd2, 32'd2, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd3, 32'd3, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd4, 32'd3, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd0, 32'hFFFFFFFE, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd1, 32'hFFFFFFFE, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd3, 32'hFFFFFFFE, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd4, 32'hFFFFFFFD, 1'b0, 1'b1);
      lit32(32'hC0200000, 3'd7, 32'hFFFFFFFD, 1'b0, 1'b1);
      // Bounds
      lit32(32'hCF000000, 3'd0, 32'h80000000, 1'b0, 1'b0);
      lit32(32'h4F000000, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
      lit32(32'h7FC00000, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
      lit32(32'hFFC00000, 3'd1, 32'h7FFFFFFF, 1'b1, 1'b0);
      lit32(32'hFF800000, 3'd0, 32'h80000000, 1'b1, 1'b0);
      // Small values
      lit32(32'h3ECCCCCD, 3'd3, 32'd1, 1'b0, 1'b1);
      lit32(32'h3ECCCCCD, 3'd0, 32'd0, 1'b0, 1'b1);
      lit32(32'h3F000000, 3'd0, 32'd0, 1'b0, 1'b1);
      lit32(32'h3FC00000, 3'd0, 32'd2, 1'b0, 1'b1);
      lit32(32'h00000001, 3'd3, 32'd0, 1'b0, 1'b0);
      lit32(32'h80000000, 3'd2, 32'd0, 1'b0, 1'b0);
      // Wide instance
      lit64(32'h5F000000, 3'd0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0);
      lit64(32'h4F000000, 3'd0, 64'h0000000080000000, 1'b0, 1'b0);
      lit64(32'hDF000000, 3'd0, 64'h8000000000000000, 1'b0, 1'b0);
      idle(6);

      // Streaming with a forced 4-cycle stall mid-stream
      for (int i = 0; i < 4; i++) rnd_op();
      stall_cnt = 4;
      for (int i = 0; i < 4; i++) rnd_op();
      idle(10);

      // Reset with three operations in flight
      lit32(32'h40200000, 3'd3, 32'd3, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd3, 32'd3, 1'b0, 1'b1);
      lit32(32'h40200000, 3'd3, 32'd3, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      cur_lit  = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("async_reset_valid", {62'd0, out_valid_a, out_valid_b}, 64'd0);
      chk("async_reset_y32", {32'd0, out_y_a}, 64'd0);
      chk("async_reset_y64", out_y_b, 64'd0);
      chk("async_reset_flags", {60'd0, out_inv_a, out_inx_a, out_inv_b, out_inx_b}, 64'd0);
      chk("async_reset_in_ready", {63'd0, in_ready_a}, 64'd1);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      idle(6);
      lit32(32'h3FC00000, 3'd1, 32'd1, 1'b0, 1'b1);
      idle(6);

      // Randomized traffic with random backpressure and input gaps
      rnd_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rnd_op();
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      rnd_ready = 1'b0;

      // Drain
      n = 0;
      while ((q.size() != 0 || out_valid_a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: outstanding=%0d required 0", q.size());
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
